// File: rtl/eth_pkg.sv
// Shared Ethernet constants, FSM state encoding and header helpers
// for the TX header inserter.
package eth_pkg;

  localparam int ETH_HDR_BYTES = 14;
  localparam logic [15:0] ETH_TYPE_USR = 16'h88B5;
  localparam logic [47:0] ETH_DST_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] ETH_SRC_MAC = 48'h02_00_00_00_00_02;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    TAIL = 2'd2
  } state_t;

  // Empty count of the extra beat that carries the last HDR_BYTES payload bytes.
  function automatic int calc_tail_empty(input int e, input int b, input int hdr_bytes);
    return b - hdr_bytes + e;
  endfunction

  function automatic logic [ETH_HDR_BYTES*8-1:0] make_hdr(
    input logic [47:0] dst,
    input logic [47:0] src,
    input logic [15:0] eth_type
  );
    return {dst, src, eth_type};
  endfunction

endpackage

// File: rtl/eth_hdr_insert_if.sv
// Payload-in / frame-out stream bundle of the header inserter.
// The slave modport is the inserter; the master modport is the user/MAC side.
interface eth_hdr_insert_if
  import eth_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int EMPTY_W   = $clog2(DATA_W/8),
  parameter int HDR_BYTES = ETH_HDR_BYTES
);

  logic [HDR_BYTES*8-1:0] in_hdr;
  logic [DATA_W-1:0]      in_data;
  logic                   in_valid;
  logic                   in_sop;
  logic                   in_eop;
  logic [EMPTY_W-1:0]     in_empty;
  logic                   in_ready;

  logic [DATA_W-1:0]      out_data;
  logic                   out_valid;
  logic                   out_sop;
  logic                   out_eop;
  logic [EMPTY_W-1:0]     out_empty;
  logic                   out_ready;

  modport slave (
    input  in_hdr, in_data, in_valid, in_sop, in_eop, in_empty,
    output in_ready,
    output out_data, out_valid, out_sop, out_eop, out_empty,
    input  out_ready
  );

  modport master (
    output in_hdr, in_data, in_valid, in_sop, in_eop, in_empty,
    input  in_ready,
    input  out_data, out_valid, out_sop, out_eop, out_empty,
    output out_ready
  );

endinterface

// File: rtl/eth_hdr_insert.sv
// Prepends a per-frame header to a byte-packed payload stream, realigning every
// beat by HDR_BYTES and adding a tail beat only when the last bytes overflow.
module eth_hdr_insert
  import eth_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int EMPTY_W   = $clog2(DATA_W/8),
  parameter int HDR_BYTES = ETH_HDR_BYTES,
  parameter int CNT_W     = 32
)(
  input  logic             clk,
  input  logic             rst,
  eth_hdr_insert_if.slave  bus,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int B = DATA_W/8;
  localparam int H = HDR_BYTES*8;

  state_t             state_r;
  logic [H-1:0]       carry_r;
  logic [EMPTY_W-1:0] e_last_r;
  logic [DATA_W-1:0]  out_data_r;
  logic               out_valid_r;
  logic               out_sop_r;
  logic               out_eop_r;
  logic [EMPTY_W-1:0] out_empty_r;
  logic [CNT_W-1:0]   pkt_cnt_r;
  logic [CNT_W-1:0]   drop_cnt_r;

  logic               out_free_s;
  logic               accept_s;
  logic [DATA_W-1:0]  keep_s;
  logic [DATA_W-1:0]  din_s;
  logic               fits_s;
  state_t             nxt_state_s;
  logic               nxt_eop_s;
  logic [EMPTY_W-1:0] nxt_empty_s;

  assign out_free_s    = !out_valid_r || bus.out_ready;
  assign bus.in_ready  = out_free_s && (state_r != TAIL);
  assign accept_s      = bus.in_valid && bus.in_ready;

  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sop   = out_sop_r;
  assign bus.out_eop   = out_eop_r;
  assign bus.out_empty = out_empty_r;
  assign pkt_cnt       = pkt_cnt_r;
  assign drop_cnt      = drop_cnt_r;

  // Zero the unused bytes of an eop beat so they never leak into the frame or the carry.
  always_comb begin
    keep_s = {DATA_W{1'b1}};
    if (bus.in_eop) begin
      keep_s = {DATA_W{1'b1}} << {bus.in_empty, 3'b000};
    end else begin
      keep_s = {DATA_W{1'b1}};
    end
    din_s = bus.in_data & keep_s;
  end

  // EOP rule: finish in this beat if the shifted-out bytes were all empty, else owe a tail.
  always_comb begin
    fits_s      = (bus.in_empty >= EMPTY_W'(HDR_BYTES));
    nxt_state_s = BODY;
    nxt_eop_s   = 1'b0;
    nxt_empty_s = {EMPTY_W{1'b0}};
    if (!bus.in_eop) begin
      nxt_state_s = BODY;
    end else if (fits_s) begin
      nxt_state_s = IDLE;
      nxt_eop_s   = 1'b1;
      nxt_empty_s = bus.in_empty - EMPTY_W'(HDR_BYTES);
    end else begin
      nxt_state_s = TAIL;
    end
  end

  // Framing FSM, output register stage and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      carry_r     <= {H{1'b0}};
      e_last_r    <= {EMPTY_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
      out_empty_r <= {EMPTY_W{1'b0}};
      pkt_cnt_r   <= {CNT_W{1'b0}};
      drop_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (out_valid_r && bus.out_ready && out_eop_r) begin
        pkt_cnt_r <= pkt_cnt_r + CNT_W'(1);
      end
      if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (accept_s && bus.in_sop) begin
            out_data_r  <= {bus.in_hdr, din_s[DATA_W-1:H]};
            out_valid_r <= 1'b1;
            out_sop_r   <= 1'b1;
            out_eop_r   <= nxt_eop_s;
            out_empty_r <= nxt_empty_s;
            carry_r     <= din_s[H-1:0];
            e_last_r    <= bus.in_empty;
            state_r     <= nxt_state_s;
          end else if (accept_s) begin
            drop_cnt_r  <= drop_cnt_r + CNT_W'(1);
          end
        end
        BODY: begin
          // A stray mid-frame sop is deliberately treated as an ordinary body beat.
          if (accept_s) begin
            out_data_r  <= {carry_r, din_s[DATA_W-1:H]};
            out_valid_r <= 1'b1;
            out_sop_r   <= 1'b0;
            out_eop_r   <= nxt_eop_s;
            out_empty_r <= nxt_empty_s;
            carry_r     <= din_s[H-1:0];
            e_last_r    <= bus.in_empty;
            state_r     <= nxt_state_s;
          end
        end
        TAIL: begin
          if (out_free_s) begin
            out_data_r  <= {carry_r, {(DATA_W-H){1'b0}}};
            out_valid_r <= 1'b1;
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b1;
            out_empty_r <= EMPTY_W'(calc_tail_empty(int'(e_last_r), B, HDR_BYTES));
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
